// File: rtl/render_ctrl.sv
// render_ctrl: command sequencer for the Mandelbrot renderer.
// Parses the command-buffer byte stream, latches the view parameters and
// runs one frame by counting completed pixels into the framebuffer address.
module render_ctrl #(
    parameter int CMD_AW = 8,
    parameter int PIXELS = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              cmd_valid,
    input  logic [CMD_AW-1:0] cmd_len,
    output logic [CMD_AW-1:0] cmd_raddr,
    input  logic [7:0]        cmd_data,
    output logic [15:0]       cx,
    output logic [15:0]       cy,
    output logic [2:0]        zoom,
    output logic              run,
    input  logic              pix_done,
    output logic [15:0]       pix_addr,
    output logic              frame_done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_RENDER = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SET_CX   = 8'h01;
    localparam logic [7:0] OP_SET_CY   = 8'h02;
    localparam logic [7:0] OP_SET_ZOOM = 8'h03;
    localparam logic [7:0] OP_RENDER   = 8'h10;

    localparam logic [1:0] TGT_CX   = 2'd0;
    localparam logic [1:0] TGT_CY   = 2'd1;
    localparam logic [1:0] TGT_ZOOM = 2'd2;

    // The pixel counter only needs to reach PIXELS-1; the frame ends on the
    // pulse that arrives while it holds that value.
    localparam int CNT_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

    logic [2:0]        state;
    logic [CMD_AW-1:0] len;
    logic [CMD_AW-1:0] ptr;
    logic [1:0]        pend_cnt;
    logic [1:0]        pend_tgt;
    logic [7:0]        shadow;
    logic [CNT_W-1:0]  pix_cnt;

    logic              start;
    logic              last_byte;
    logic [CMD_AW-1:0] ptr_next;

    // Decode a parse start and whether the byte being consumed is the last one.
    always_comb begin
        start     = cmd_valid && (cmd_len != '0) && ((state == S_IDLE) || (state == S_DONE));
        ptr_next  = ptr + CMD_AW'(1);
        last_byte = (ptr_next == len);
    end

    // Main sequencer: parse bytes two cycles each, then count pixels until the frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            ptr        <= '0;
            pend_cnt   <= 2'd0;
            pend_tgt   <= TGT_CX;
            shadow     <= 8'd0;
            pix_cnt    <= '0;
            cmd_raddr  <= '0;
            cx         <= 16'd0;
            cy         <= 16'd0;
            zoom       <= 3'd0;
            run        <= 1'b0;
            pix_addr   <= 16'd0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            run        <= 1'b0;
            frame_done <= 1'b0;
            pend_cnt   <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len        <= cmd_len;
                        ptr        <= '0;
                        cmd_raddr  <= '0;
                        err        <= 1'b0;
                        frame_done <= 1'b0;
                        pend_cnt   <= 2'd0;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_DATA;
                end
                S_DATA: begin
                    ptr <= ptr_next;
                    if (pend_cnt == 2'd0) begin
                        case (cmd_data)
                            OP_NOP: begin
                                if (last_byte) begin
                                    state <= S_IDLE;
                                end else begin
                                    cmd_raddr <= ptr_next;
                                    state     <= S_ADDR;
                                end
                            end
                            OP_SET_CX, OP_SET_CY, OP_SET_ZOOM: begin
                                pend_tgt <= (cmd_data == OP_SET_CX) ? TGT_CX :
                                            (cmd_data == OP_SET_CY) ? TGT_CY : TGT_ZOOM;
                                pend_cnt <= (cmd_data == OP_SET_ZOOM) ? 2'd1 : 2'd2;
                                if (last_byte) begin
                                    err   <= 1'b1;
                                    state <= S_IDLE;
                                end else begin
                                    cmd_raddr <= ptr_next;
                                    state     <= S_ADDR;
                                end
                            end
                            OP_RENDER: begin
                                pix_addr <= 16'd0;
                                pix_cnt  <= '0;
                                run      <= 1'b1;
                                state    <= S_RENDER;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end
                        endcase
                    end else if (pend_cnt == 2'd2) begin
                        shadow   <= cmd_data;
                        pend_cnt <= 2'd1;
                        if (last_byte) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cmd_raddr <= ptr_next;
                            state     <= S_ADDR;
                        end
                    end else begin
                        case (pend_tgt)
                            TGT_CX:  cx   <= {cmd_data, shadow};
                            TGT_CY:  cy   <= {cmd_data, shadow};
                            default: zoom <= cmd_data[2:0];
                        endcase
                        pend_cnt <= 2'd0;
                        if (last_byte) begin
                            state <= S_IDLE;
                        end else begin
                            cmd_raddr <= ptr_next;
                            state     <= S_ADDR;
                        end
                    end
                end
                S_RENDER: begin
                    if (pix_done) begin
                        pix_addr <= pix_addr + 16'd1;
                        if (pix_cnt == LAST_PIX) begin
                            run        <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_ctrl.sv
// tb_render_ctrl: scoreboard bench for render_ctrl with a 16-pixel frame.
module tb_render_ctrl;

    localparam int CMD_AW = 8;
    localparam int PIXELS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_len = 8'd0;
    logic [7:0]  cmd_raddr;
    logic [7:0]  cmd_data;
    logic [15:0] cx;
    logic [15:0] cy;
    logic [2:0]  zoom;
    logic        run;
    logic        pix_done = 1'b0;
    logic [15:0] pix_addr;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        run;
        logic        done;
    } pix_exp_t;

    pix_exp_t    sb[$];
    int          m_cnt;
    logic [15:0] m_addr;
    logic        m_run;
    logic        m_done;

    logic [7:0] mem [256];

    render_ctrl #(.CMD_AW(CMD_AW), .PIXELS(PIXELS)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_raddr(cmd_raddr), .cmd_data(cmd_data),
        .cx(cx), .cy(cy), .zoom(zoom), .run(run),
        .pix_done(pix_done), .pix_addr(pix_addr),
        .frame_done(frame_done), .err(err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Command RAM model with one cycle of read latency
    always @(posedge clk) cmd_data <= mem[cmd_raddr];

    // Hard stop in case something never settles
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        tick();
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
    endtask

    task automatic wait_run(input int bound, output int cycles, output bit seen,
                            output logic [7:0] max_raddr);
        seen      = 1'b0;
        cycles    = 0;
        max_raddr = cmd_raddr;
        while (!seen && cycles < bound) begin
            tick();
            cycles++;
            if (cmd_raddr > max_raddr) max_raddr = cmd_raddr;
            if (run === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic model_start();
        m_cnt  = 0;
        m_addr = 16'd0;
        m_run  = 1'b1;
        m_done = 1'b0;
        sb.delete();
    endtask

    // Pulse pix_done once and queue what the frame counter should show afterwards
    task automatic drive_pixel();
        if (m_run) begin
            m_addr = m_addr + 16'd1;
            m_cnt++;
            if (m_cnt == PIXELS) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end
        sb.push_back({m_addr, m_run, m_done});
        pix_done = 1'b1;
        tick();
        pix_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err} !== 62'd0) begin
            fails++;
            $display("[TB] FAIL reset_values: got %h expected 0",
                     {cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_render();
        int cycles;
        bit seen;
        logic [7:0] mr;
        pix_exp_t e;
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h10;
        mem[3] = 8'h02; mem[4] = 8'h00; mem[5] = 8'h20;
        mem[6] = 8'h03; mem[7] = 8'h06; mem[8] = 8'h10;
        send_cmd(9);
        wait_run(40, cycles, seen, mr);
        checks++;
        if (!seen || cycles != 18) begin
            fails++;
            $display("[TB] FAIL full_run_latency: got seen=%0d cycles=%0d expected seen=1 cycles=18", seen, cycles);
        end
        checks++;
        if ({cx, cy, zoom, err, pix_addr, frame_done} !== {16'h1000, 16'h2000, 3'd6, 1'b0, 16'd0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL full_params: got cx=%h cy=%h zoom=%0d err=%b pix=%h fd=%b expected 1000 2000 6 0 0000 0",
                     cx, cy, zoom, err, pix_addr, frame_done);
        end
        model_start();
        for (int i = 0; i < PIXELS; i++) begin
            drive_pixel();
            e = sb.pop_front();
            checks++;
            if ({pix_addr, run, frame_done} !== {e.addr, e.run, e.done}) begin
                fails++;
                $display("[TB] FAIL full_pixel_%0d: got addr=%h run=%b fd=%b expected addr=%h run=%b fd=%b",
                         i, pix_addr, run, frame_done, e.addr, e.run, e.done);
            end
            repeat (3) tick();
        end
        checks++;
        if ({frame_done, run, pix_addr, cx, cy, zoom} !== {1'b1, 1'b0, 16'd16, 16'h1000, 16'h2000, 3'd6}) begin
            fails++;
            $display("[TB] FAIL full_done_hold: got fd=%b run=%b pix=%h cx=%h cy=%h zoom=%0d expected 1 0 0010 1000 2000 6",
                     frame_done, run, pix_addr, cx, cy, zoom);
        end
    endtask

    task automatic test_truncated();
        bit seen_run;
        mem[0] = 8'h01; mem[1] = 8'h34;
        send_cmd(2);
        checks++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL trunc_fd_clear: got %b expected 0", frame_done);
        end
        seen_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (run === 1'b1) seen_run = 1'b1;
        end
        checks++;
        if ({seen_run, err, cx, cmd_raddr} !== {1'b0, 1'b1, 16'h1000, 8'd1}) begin
            fails++;
            $display("[TB] FAIL trunc_result: got run_seen=%b err=%b cx=%h raddr=%0d expected 0 1 1000 1",
                     seen_run, err, cx, cmd_raddr);
        end
    endtask

    task automatic test_bad_opcode();
        int cycles;
        bit seen;
        logic [7:0] mr;
        mem[0] = 8'h00; mem[1] = 8'h7F; mem[2] = 8'h10;
        send_cmd(3);
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL badop_err_clear: got %b expected 0", err);
        end
        wait_run(12, cycles, seen, mr);
        checks++;
        if ({seen, mr, err} !== {1'b0, 8'd1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL badop_result: got run_seen=%b max_raddr=%0d err=%b expected 0 1 1",
                     seen, mr, err);
        end
    endtask

    task automatic test_abort();
        int cycles;
        bit seen;
        logic [7:0] mr;
        pix_exp_t e;
        mem[0] = 8'h10;
        send_cmd(1);
        wait_run(10, cycles, seen, mr);
        checks++;
        if (!seen || cycles != 2) begin
            fails++;
            $display("[TB] FAIL abort_run_latency: got seen=%0d cycles=%0d expected seen=1 cycles=2", seen, cycles);
        end
        model_start();
        for (int i = 0; i < 5; i++) begin
            drive_pixel();
            e = sb.pop_front();
            checks++;
            if ({pix_addr, run, frame_done} !== {e.addr, e.run, e.done}) begin
                fails++;
                $display("[TB] FAIL abort_pixel_%0d: got addr=%h run=%b fd=%b expected addr=%h run=%b fd=%b",
                         i, pix_addr, run, frame_done, e.addr, e.run, e.done);
            end
            repeat (3) tick();
        end
        abort    = 1'b1;
        pix_done = 1'b1;
        tick();
        abort    = 1'b0;
        pix_done = 1'b0;
        checks++;
        if ({run, frame_done, pix_addr, err, cx, zoom} !== {1'b0, 1'b0, 16'd5, 1'b0, 16'h1000, 3'd6}) begin
            fails++;
            $display("[TB] FAIL abort_effect: got run=%b fd=%b pix=%h err=%b cx=%h zoom=%0d expected 0 0 0005 0 1000 6",
                     run, frame_done, pix_addr, err, cx, zoom);
        end
        pix_done = 1'b1;
        tick();
        pix_done = 1'b0;
        checks++;
        if (pix_addr !== 16'd5) begin
            fails++;
            $display("[TB] FAIL abort_stray_pix: got %h expected 0005", pix_addr);
        end
        mem[0] = 8'h03; mem[1] = 8'h05;
        send_cmd(2);
        repeat (4) tick();
        checks++;
        if ({zoom, err, run} !== {3'd5, 1'b0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL abort_reaccept: got zoom=%0d err=%b run=%b expected 5 0 0", zoom, err, run);
        end
    endtask

    task automatic test_render_ignores();
        int cycles;
        bit seen;
        logic [7:0] mr;
        pix_exp_t e;
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h10;
        send_cmd(3);
        pix_done = 1'b1;
        tick();
        pix_done = 1'b0;
        checks++;
        if (pix_addr !== 16'd5) begin
            fails++;
            $display("[TB] FAIL early_pix_ignored: got %h expected 0005", pix_addr);
        end
        wait_run(20, cycles, seen, mr);
        checks++;
        if (!seen || cycles != 5 || pix_addr !== 16'd0) begin
            fails++;
            $display("[TB] FAIL ign_run_latency: got seen=%0d cycles=%0d pix=%h expected 1 5 0000", seen, cycles, pix_addr);
        end
        model_start();
        drive_pixel();
        e = sb.pop_front();
        checks++;
        if ({pix_addr, run, frame_done} !== {e.addr, e.run, e.done}) begin
            fails++;
            $display("[TB] FAIL ign_first_pixel: got addr=%h run=%b fd=%b expected addr=%h run=%b fd=%b",
                     pix_addr, run, frame_done, e.addr, e.run, e.done);
        end
        send_cmd(1);
        for (int i = 1; i < PIXELS; i++) begin
            drive_pixel();
            e = sb.pop_front();
            checks++;
            if ({pix_addr, run, frame_done} !== {e.addr, e.run, e.done}) begin
                fails++;
                $display("[TB] FAIL ign_pixel_%0d: got addr=%h run=%b fd=%b expected addr=%h run=%b fd=%b",
                         i, pix_addr, run, frame_done, e.addr, e.run, e.done);
            end
            tick();
        end
        send_cmd(0);
        repeat (3) tick();
        checks++;
        if ({frame_done, run} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL done_len0_ignored: got fd=%b run=%b expected fd=1 run=0", frame_done, run);
        end
        mem[0] = 8'h10;
        send_cmd(1);
        checks++;
        if (frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL done_restart_fd: got %b expected 0", frame_done);
        end
        tick();
        tick();
        checks++;
        if ({run, pix_addr} !== {1'b1, 16'd0}) begin
            fails++;
            $display("[TB] FAIL done_restart_run: got run=%b pix=%h expected 1 0000", run, pix_addr);
        end
    endtask

    task automatic test_reset_mid();
        drive_pixel();
        tick();
        drive_pixel();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err} !== 62'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_render: got %h expected 0",
                     {cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err});
        end
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h10;
        mem[3] = 8'h02; mem[4] = 8'h00; mem[5] = 8'h20;
        mem[6] = 8'h03; mem[7] = 8'h06; mem[8] = 8'h10;
        send_cmd(9);
        repeat (8) tick();
        checks++;
        if (cx !== 16'h1000) begin
            fails++;
            $display("[TB] FAIL reset_mid_progress: got cx=%h expected 1000", cx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err} !== 62'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_parse: got %h expected 0",
                     {cmd_raddr, cx, cy, zoom, run, pix_addr, frame_done, err});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        $display("[TB] render_ctrl bench start");
        test_reset();
        test_full_render();
        test_truncated();
        test_bad_opcode();
        test_abort();
        test_render_ignores();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
